// File: rtl/rom_seq_pkg.sv
// Shared types for the ROM pattern sequencer.
// The DWELL encoding is reserved even when ROM_SEQ_DWELL_EN is undefined.
package rom_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      PRESENT = 3'd2,
      DWELL   = 3'd3,
      DONE    = 3'd4
   } rom_seq_state_t;

endpackage

// File: rtl/rom_pattern_sequencer.sv
// Address sequencer and output register for an asynchronous ROM, valid/ready output.
// Optional inter-word dwell is enabled by defining ROM_SEQ_DWELL_EN.
module rom_pattern_sequencer
   import rom_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  loop_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  wrap
`ifdef ROM_SEQ_DWELL_EN
   ,
   input  logic [7:0]            dwell
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

   rom_seq_state_t        state_r, state_s;
   logic [ADDR_WIDTH-1:0] addr_r, addr_s;
   logic [DATA_WIDTH-1:0] data_r, data_s;
   logic                  valid_r, valid_s;
   logic                  busy_r, busy_s;
   logic                  done_r, done_s;
   logic                  wrap_r, wrap_s;
   logic                  hs_s;
   logic                  last_s;
   logic                  final_s;
`ifdef ROM_SEQ_DWELL_EN
   logic [7:0]            cnt_r, cnt_s;
`endif

   assign hs_s    = valid_r && data_ready;
   assign last_s  = (addr_r == LAST);
   // The final handshake is the one that ends a single pass.
   assign final_s = last_s && !loop_en;

   // State and output registers
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_r <= IDLE;
         addr_r  <= {ADDR_WIDTH{1'b0}};
         data_r  <= {DATA_WIDTH{1'b0}};
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         wrap_r  <= 1'b0;
`ifdef ROM_SEQ_DWELL_EN
         cnt_r   <= 8'd0;
`endif
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         data_r  <= data_s;
         valid_r <= valid_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         wrap_r  <= wrap_s;
`ifdef ROM_SEQ_DWELL_EN
         cnt_r   <= cnt_s;
`endif
      end
   end

   // Next-state logic; stop overrides any handshake or start
   always_comb begin
      state_s = state_r;
      if (stop) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) state_s = FETCH;
               else       state_s = IDLE;
            end
            FETCH: state_s = PRESENT;
            PRESENT: begin
               if (!hs_s)        state_s = PRESENT;
               else if (final_s) state_s = DONE;
`ifdef ROM_SEQ_DWELL_EN
               else if (dwell != 8'd0) state_s = DWELL;
`endif
               else              state_s = FETCH;
            end
`ifdef ROM_SEQ_DWELL_EN
            DWELL: begin
               if (cnt_r == 8'd1) state_s = FETCH;
               else               state_s = DWELL;
            end
`endif
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      addr_s  = addr_r;
      data_s  = data_r;
      valid_s = 1'b0;
      done_s  = 1'b0;
      wrap_s  = 1'b0;
      busy_s  = (state_s != IDLE);
`ifdef ROM_SEQ_DWELL_EN
      cnt_s   = cnt_r;
`endif
      if (stop) begin
         addr_s = {ADDR_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: addr_s = {ADDR_WIDTH{1'b0}};
            FETCH: begin
               data_s  = rom_q;
               valid_s = 1'b1;
            end
            PRESENT: begin
               if (hs_s) begin
                  // Wrap is explicit rather than relying on counter overflow.
                  if (last_s) begin
                     addr_s = {ADDR_WIDTH{1'b0}};
                     wrap_s = loop_en;
                     done_s = !loop_en;
                  end else begin
                     addr_s = addr_r + ADDR_WIDTH'(1);
                  end
`ifdef ROM_SEQ_DWELL_EN
                  cnt_s = dwell;
`endif
               end else begin
                  valid_s = 1'b1;
               end
            end
`ifdef ROM_SEQ_DWELL_EN
            DWELL: cnt_s = cnt_r - 8'd1;
`endif
            DONE:    addr_s = {ADDR_WIDTH{1'b0}};
            default: addr_s = {ADDR_WIDTH{1'b0}};
         endcase
      end
   end

   assign rom_addr   = addr_r;
   assign data_out   = data_r;
   assign data_valid = valid_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign wrap       = wrap_r;

endmodule
